// File: rtl/deser_load_ctrl.sv
// Sequencer streaming FEATURES input + FEATURES hidden elements per frame from SRAM into the
// LSTM deserializer, then presenting each frame with valid/ready. Option: DESER_LOAD_CTRL_PERF_EN.
module deser_load_ctrl #(
  parameter int unsigned ELEMENT_BITS = 8,
  parameter int unsigned FEATURES     = 4,
  parameter int unsigned ADDR_BITS    = 10,
  parameter int unsigned FRAME_BITS   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [ADDR_BITS-1:0]    i_cmd_base_addr,
  input  logic [FRAME_BITS-1:0]   i_cmd_num_frames,
  output logic                    o_rd_en,
  output logic [ADDR_BITS-1:0]    o_rd_addr,
  input  logic [ELEMENT_BITS-1:0] i_rd_data,
  output logic                    o_deser_start,
  output logic [ELEMENT_BITS-1:0] o_deser_data,
  output logic                    o_frame_valid,
  input  logic                    i_frame_ready,
  output logic [FRAME_BITS-1:0]   o_frame_idx,
  output logic                    o_busy,
  output logic                    o_done
`ifdef DESER_LOAD_CTRL_PERF_EN
  ,
  output logic [31:0]             o_perf_busy_cycles,
  output logic [31:0]             o_perf_stall_cycles
`endif
);

  localparam int unsigned FrameElems = 2 * FEATURES;
  localparam int unsigned KBits      = (FrameElems > 1) ? $clog2(FrameElems) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StLast, StPresent} state_e;

  state_e                  r_state, w_state_d;
  logic [ADDR_BITS-1:0]    r_addr;
  logic [FRAME_BITS-1:0]   r_num;
  logic [FRAME_BITS-1:0]   r_idx;
  logic [KBits-1:0]        r_k;
  logic                    r_rd_en_q;
  logic                    r_done;

  logic                    w_accept;
  logic                    w_handshake;
  logic                    w_k_last;
  logic                    w_last_frame;
  logic [FRAME_BITS-1:0]   w_idx_inc;

  assign w_accept     = (r_state == StIdle) && i_cmd_valid;
  assign w_handshake  = (r_state == StPresent) && i_frame_ready;
  assign w_k_last     = (r_k == KBits'(FrameElems - 1));
  assign w_idx_inc    = r_idx + FRAME_BITS'(1);
  assign w_last_frame = (w_idx_inc == r_num);

  always_comb begin
    w_state_d     = r_state;
    o_cmd_ready   = 1'b0;
    o_rd_en       = 1'b0;
    o_rd_addr     = '0;
    o_deser_start = 1'b0;
    o_frame_valid = 1'b0;
    o_busy        = 1'b1;
    unique case (r_state)
      StIdle: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        if (w_accept && (i_cmd_num_frames != '0)) w_state_d = StFetch;
      end
      StFetch: begin
        o_rd_en       = 1'b1;
        o_rd_addr     = r_addr;
        o_deser_start = (r_k == '0);
        if (w_k_last) w_state_d = StLast;
      end
      StLast: w_state_d = StPresent;
      StPresent: begin
        o_frame_valid = 1'b1;
        if (w_handshake) w_state_d = w_last_frame ? StIdle : StFetch;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Read data lands one cycle after the strobe; gate it so stale SRAM output never leaks out.
  assign o_deser_data = r_rd_en_q ? i_rd_data : '0;
  assign o_frame_idx  = r_idx;
  assign o_done       = r_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_num     <= '0;
      r_idx     <= '0;
      r_k       <= '0;
      r_rd_en_q <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_rd_en_q <= o_rd_en;
      r_done    <= (w_accept && (i_cmd_num_frames == '0)) || (w_handshake && w_last_frame);
      // Address runs contiguously across frames, so base + idx*2F + k needs no multiplier.
      if (w_accept) begin
        r_addr <= i_cmd_base_addr;
        r_num  <= i_cmd_num_frames;
        r_idx  <= '0;
      end else begin
        if (r_state == StFetch) r_addr <= r_addr + ADDR_BITS'(1);
        if (w_handshake)        r_idx  <= w_idx_inc;
      end
      if (r_state == StFetch) r_k <= w_k_last ? '0 : r_k + KBits'(1);
      else                    r_k <= '0;
    end
  end

`ifdef DESER_LOAD_CTRL_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;

  always_ff @(posedge i_clk) begin
    if (i_reset || w_accept) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (o_busy) r_perf_busy <= r_perf_busy + 32'd1;
      if ((r_state == StPresent) && !i_frame_ready) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_busy_cycles  = r_perf_busy;
  assign o_perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_deser_load_ctrl.sv
// Directed bench for deser_load_ctrl (FEATURES=4, ADDR_BITS=10); checks perf counters
// when DESER_LOAD_CTRL_PERF_EN is defined.
module tb_deser_load_ctrl;
  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [9:0] i_cmd_base_addr;
  logic [7:0] i_cmd_num_frames;
  logic       o_rd_en;
  logic [9:0] o_rd_addr;
  logic [7:0] i_rd_data;
  logic       o_deser_start;
  logic [7:0] o_deser_data;
  logic       o_frame_valid;
  logic       i_frame_ready;
  logic [7:0] o_frame_idx;
  logic       o_busy;
  logic       o_done;
`ifdef DESER_LOAD_CTRL_PERF_EN
  logic [31:0] o_perf_busy_cycles;
  logic [31:0] o_perf_stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  deser_load_ctrl #(
    .ELEMENT_BITS(8), .FEATURES(4), .ADDR_BITS(10), .FRAME_BITS(8)
  ) u_dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_cmd_valid      (i_cmd_valid),
    .o_cmd_ready      (o_cmd_ready),
    .i_cmd_base_addr  (i_cmd_base_addr),
    .i_cmd_num_frames (i_cmd_num_frames),
    .o_rd_en          (o_rd_en),
    .o_rd_addr        (o_rd_addr),
    .i_rd_data        (i_rd_data),
    .o_deser_start    (o_deser_start),
    .o_deser_data     (o_deser_data),
    .o_frame_valid    (o_frame_valid),
    .i_frame_ready    (i_frame_ready),
    .o_frame_idx      (o_frame_idx),
    .o_busy           (o_busy),
    .o_done           (o_done)
`ifdef DESER_LOAD_CTRL_PERF_EN
    ,
    .o_perf_busy_cycles  (o_perf_busy_cycles),
    .o_perf_stall_cycles (o_perf_stall_cycles)
`endif
  );

  function automatic logic [7:0] mem_f(input logic [9:0] a);
    return a[7:0] ^ 8'h5A ^ {6'd0, a[9:8]};
  endfunction

  // SRAM model: one-cycle read latency.
  always @(posedge i_clk) begin
    if (o_rd_en) i_rd_data <= mem_f(o_rd_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic issue(input logic [9:0] base, input logic [7:0] num);
    i_cmd_valid      = 1'b1;
    i_cmd_base_addr  = base;
    i_cmd_num_frames = num;
    chk("cmd_ready_idle", o_cmd_ready, 1);
    step();
    i_cmd_valid = 1'b0;
  endtask

  // Called in the first FETCH cycle; returns in the first PRESENT cycle.
  task automatic fetch_frame(input logic [9:0] a0, input logic [7:0] idx);
    logic [9:0] a;
    for (int k = 0; k < 8; k++) begin
      a = a0 + 10'(k);
      chk("rd_en", o_rd_en, 1);
      chk("rd_addr", o_rd_addr, a);
      chk("deser_start", o_deser_start, (k == 0) ? 1 : 0);
      if (k > 0) chk("deser_data", o_deser_data, mem_f(a - 10'd1));
      chk("frame_idx", o_frame_idx, idx);
      chk("frame_valid_fetch", o_frame_valid, 0);
      chk("busy", o_busy, 1);
      chk("cmd_ready_busy", o_cmd_ready, 0);
      chk("done_fetch", o_done, 0);
      step();
    end
    a = a0 + 10'd7;
    chk("rd_en_last", o_rd_en, 0);
    chk("deser_data_last", o_deser_data, mem_f(a));
    chk("frame_valid_last", o_frame_valid, 0);
    step();
    chk("frame_valid", o_frame_valid, 1);
    chk("frame_idx_present", o_frame_idx, idx);
    chk("rd_en_present", o_rd_en, 0);
    chk("deser_data_present", o_deser_data, 0);
  endtask

  initial begin
    i_reset          = 1'b1;
    i_cmd_valid      = 1'b0;
    i_cmd_base_addr  = '0;
    i_cmd_num_frames = '0;
    i_frame_ready    = 1'b1;
    repeat (3) step();
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_rd_addr", o_rd_addr, 0);
    chk("rst_start", o_deser_start, 0);
    chk("rst_data", o_deser_data, 0);
    chk("rst_valid", o_frame_valid, 0);
    chk("rst_idx", o_frame_idx, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    i_reset = 1'b0;
    step();

    // Single frame, no backpressure
    issue(10'h010, 8'd1);
    fetch_frame(10'h010, 8'd0);
    chk("done_before_hs", o_done, 0);
    step();
    chk("done_single", o_done, 1);
    chk("idle_single", o_cmd_ready, 1);
    chk("busy_single", o_busy, 0);
    step();
    chk("done_drop", o_done, 0);

    // Three frames back to back: restarts every 10 cycles
    issue(10'h100, 8'd3);
    for (int f = 0; f < 3; f++) begin
      fetch_frame(10'h100 + 10'(8 * f), 8'(f));
      chk("done_mid", o_done, 0);
      step();
    end
    chk("done_three", o_done, 1);
    chk("busy_three", o_busy, 0);
    step();
    chk("done_three_drop", o_done, 0);

    // Backpressure: five stall cycles in PRESENT
    i_frame_ready = 1'b0;
    issue(10'h020, 8'd2);
    fetch_frame(10'h020, 8'd0);
    for (int s = 0; s < 5; s++) begin
      i_cmd_valid = 1'b1;
      chk("stall_valid", o_frame_valid, 1);
      chk("stall_rd_en", o_rd_en, 0);
      chk("stall_start", o_deser_start, 0);
      chk("stall_cmd_ready", o_cmd_ready, 0);
      step();
    end
    i_cmd_valid   = 1'b0;
    i_frame_ready = 1'b1;
    chk("stall_valid_hold", o_frame_valid, 1);
    chk("stall_idx", o_frame_idx, 0);
    step();
    fetch_frame(10'h028, 8'd1);
    step();
    chk("done_bp", o_done, 1);
`ifdef DESER_LOAD_CTRL_PERF_EN
    chk("perf_stall", o_perf_stall_cycles, 5);
    chk("perf_busy", o_perf_busy_cycles, 25);
`endif
    step();

    // Address wrap-around
    issue(10'h3FC, 8'd1);
    fetch_frame(10'h3FC, 8'd0);
    step();
    chk("done_wrap", o_done, 1);
    step();

    // Zero-frame command
    issue(10'h200, 8'd0);
    chk("zero_done", o_done, 1);
    chk("zero_rd_en", o_rd_en, 0);
    chk("zero_start", o_deser_start, 0);
    chk("zero_cmd_ready", o_cmd_ready, 1);
    chk("zero_busy", o_busy, 0);
    step();
    chk("zero_done_drop", o_done, 0);
    chk("zero_rd_en2", o_rd_en, 0);

    // Reset in the middle of FETCH (k=3)
    issue(10'h040, 8'd2);
    for (int k = 0; k < 3; k++) step();
    chk("pre_rst_addr", o_rd_addr, 10'h043);
    i_reset = 1'b1;
    step();
    chk("mid_rst_rd_en", o_rd_en, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_valid", o_frame_valid, 0);
    chk("mid_rst_start", o_deser_start, 0);
    chk("mid_rst_data", o_deser_data, 0);
    chk("mid_rst_ready", o_cmd_ready, 1);
    i_reset = 1'b0;
    step();
    chk("post_rst_rd_en", o_rd_en, 0);
    issue(10'h050, 8'd1);
    fetch_frame(10'h050, 8'd0);
    step();
    chk("done_post_rst", o_done, 1);
    chk("busy_post_rst", o_busy, 0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
